// File: rtl/sized_fifo_lvl.sv
`default_nettype none
// ============================================================================
// Module      : sized_fifo_lvl
// Description : Parametrised-depth synchronous FIFO with occupancy count,
//               programmable almost-full / almost-empty flags and sticky
//               overflow / underflow error flags. ENQ/DEQ/FULL_N/EMPTY_N/CLR
//               handshake matches the depth-1 FIFO it succeeds.
// Revision    : 1.0 - initial release
// ============================================================================
module sized_fifo_lvl #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AW       = 2,
    parameter int AF_LEVEL = 3,
    parameter int AE_LEVEL = 1,
    parameter int GUARDED  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D_IN,
    input  logic             ENQ,
    input  logic             DEQ,
    input  logic             CLR,
    output logic [WIDTH-1:0] D_OUT,
    output logic             FULL_N,
    output logic             EMPTY_N,
    output logic [AW:0]      COUNT,
    output logic             ALMOST_FULL,
    output logic             ALMOST_EMPTY,
    output logic             OVF,
    output logic             UNF
);

    // Count-width copies of the integer parameters keep comparisons width-clean.
    localparam logic [AW:0]   C_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_AF_LEVEL = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]   C_AE_LEVEL = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0]   C_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);
    localparam bit            C_GUARDED  = (GUARDED != 0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic             unf_q,    unf_d;
    logic             enq_ok;
    logic             deq_ok;

    // Acceptance decisions and next-state for pointers, count, storage and error flags.
    always_comb begin
        enq_ok   = 1'b0;
        deq_ok   = 1'b0;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (CLR) begin
            // Clear drops all entries; requests in the same cycle are ignored
            // and are not treated as errors.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // When unguarded, a full FIFO can accept a write into the slot
            // being freed by a simultaneous read.
            enq_ok = ENQ && ((count_q < C_DEPTH) ||
                             (!C_GUARDED && DEQ && (count_q == C_DEPTH)));
            deq_ok = DEQ && (count_q != '0);

            if (enq_ok) begin
                mem_d[wr_ptr_q] = D_IN;
                wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
            end
            if (deq_ok) begin
                rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            end

            if (enq_ok && !deq_ok) begin
                count_d = count_q + C_CNT_ONE;
            end else if (!enq_ok && deq_ok) begin
                count_d = count_q - C_CNT_ONE;
            end

            ovf_d = ovf_q | (ENQ & ~enq_ok);
            unf_d = unf_q | (DEQ & ~deq_ok);
        end
    end

    // Control state register; the error flags survive CLR and only RST clears them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array carries no reset; contents are meaningless until written.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

`ifdef SIZED_FIFO_LVL_SIM_WARN
    // Simulation-only notice whenever a request is rejected.
    always_ff @(posedge CLK) begin
        if (!RST && !CLR && ENQ && !enq_ok) begin
            $display("%m: warning, enqueue rejected (overflow) at %0t", $time);
        end
        if (!RST && !CLR && DEQ && !deq_ok) begin
            $display("%m: warning, dequeue rejected (underflow) at %0t", $time);
        end
    end
`endif

    // All status outputs derive from registered state only.
    assign D_OUT        = mem_q[rd_ptr_q];
    assign FULL_N       = (count_q != C_DEPTH);
    assign EMPTY_N      = (count_q != '0);
    assign COUNT        = count_q;
    assign ALMOST_FULL  = (count_q >= C_AF_LEVEL);
    assign ALMOST_EMPTY = (count_q <= C_AE_LEVEL);
    assign OVF          = ovf_q;
    assign UNF          = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_sized_fifo_lvl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sized_fifo_lvl
// Description : Self-checking bench for sized_fifo_lvl. A guarded and an
//               unguarded instance share stimulus; each is compared against a
//               queue-based reference model of the FIFO rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sized_fifo_lvl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ENQ = 1'b0;
    logic       DEQ = 1'b0;
    logic       CLR = 1'b0;
    logic [7:0] D_IN = 8'h00;

    // Index 0: guarded instance, index 1: unguarded instance.
    logic [7:0] dout [2];
    logic [2:0] cnt  [2];
    logic       fn   [2];
    logic       en   [2];
    logic       af   [2];
    logic       ae   [2];
    logic       ovf  [2];
    logic       unf  [2];

    int errors = 0;
    int checks = 0;

    // Reference model: one queue per instance plus sticky flags.
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    bit         m_ovf [2];
    bit         m_unf [2];

    // Status word {count, FULL_N, EMPTY_N, ALMOST_FULL, ALMOST_EMPTY, OVF, UNF}
    localparam logic [8:0] C_IDLE_EMPTY = 9'b000_1_0_0_1_0_0;

    always #5 CLK = ~CLK;

    sized_fifo_lvl #(
        .WIDTH(8), .DEPTH(4), .AW(2), .AF_LEVEL(3), .AE_LEVEL(1), .GUARDED(1)
    ) u_guarded (
        .CLK(CLK), .RST(RST), .D_IN(D_IN), .ENQ(ENQ), .DEQ(DEQ), .CLR(CLR),
        .D_OUT(dout[0]), .FULL_N(fn[0]), .EMPTY_N(en[0]), .COUNT(cnt[0]),
        .ALMOST_FULL(af[0]), .ALMOST_EMPTY(ae[0]), .OVF(ovf[0]), .UNF(unf[0])
    );

    sized_fifo_lvl #(
        .WIDTH(8), .DEPTH(4), .AW(2), .AF_LEVEL(3), .AE_LEVEL(1), .GUARDED(0)
    ) u_unguarded (
        .CLK(CLK), .RST(RST), .D_IN(D_IN), .ENQ(ENQ), .DEQ(DEQ), .CLR(CLR),
        .D_OUT(dout[1]), .FULL_N(fn[1]), .EMPTY_N(en[1]), .COUNT(cnt[1]),
        .ALMOST_FULL(af[1]), .ALMOST_EMPTY(ae[1]), .OVF(ovf[1]), .UNF(unf[1])
    );

    function automatic int msize(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] mhead(int i);
        if (i == 0) return q0[0];
        return q1[0];
    endfunction

    // Expected status word straight from the occupancy rules.
    function automatic logic [8:0] mflags(int i);
        int n;
        n = msize(i);
        return {3'(n), n != 4, n != 0, n >= 3, n <= 1, m_ovf[i], m_unf[i]};
    endfunction

    function automatic logic [8:0] dflags(int i);
        return {cnt[i], fn[i], en[i], af[i], ae[i], ovf[i], unf[i]};
    endfunction

    // One clock of stimulus; model advanced at the edge, outputs valid at the next falling edge.
    task automatic op(input bit e, input bit d, input bit c, input logic [7:0] din);
        int  n;
        bit  eo;
        bit  dok;
        ENQ  = e;
        DEQ  = d;
        CLR  = c;
        D_IN = din;
        @(posedge CLK);
        for (int i = 0; i < 2; i++) begin
            n   = msize(i);
            eo  = !c && e && (n < 4 || (i == 1 && d && n == 4));
            dok = !c && d && n > 0;
            if (!c && e && !eo) m_ovf[i] = 1'b1;
            if (!c && d && !dok) m_unf[i] = 1'b1;
            if (i == 0) begin
                if (c) q0.delete();
                else begin
                    if (dok) void'(q0.pop_front());
                    if (eo) q0.push_back(din);
                end
            end else begin
                if (c) q1.delete();
                else begin
                    if (dok) void'(q1.pop_front());
                    if (eo) q1.push_back(din);
                end
            end
        end
        @(negedge CLK);
        ENQ  = 1'b0;
        DEQ  = 1'b0;
        CLR  = 1'b0;
        D_IN = 8'($urandom);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        ENQ = 1'b0;
        DEQ = 1'b0;
        CLR = 1'b0;
        repeat (2) @(posedge CLK);
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dflags(i) !== C_IDLE_EMPTY) begin
                errors++;
                $display("FAIL reset_state[%0d]: got %b expected %b", i, dflags(i), C_IDLE_EMPTY);
            end
        end
        op(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dflags(i) !== C_IDLE_EMPTY) begin
                errors++;
                $display("FAIL idle_after_reset[%0d]: got %b expected %b", i, dflags(i), C_IDLE_EMPTY);
            end
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] pat [4];
        pat = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            op(1'b1, 1'b0, 1'b0, pat[k]);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (cnt[i] !== 3'(k + 1) || af[i] !== (k >= 2) || fn[i] !== (k != 3) || en[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_step%0d[%0d]: got cnt=%0d af=%b fn=%b en=%b expected cnt=%0d af=%b fn=%b en=1",
                             k, i, cnt[i], af[i], fn[i], en[i], k + 1, k >= 2, k != 3);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dout[i] !== pat[k]) begin
                    errors++;
                    $display("FAIL drain_data%0d[%0d]: got %h expected %h", k, i, dout[i], pat[k]);
                end
            end
            op(1'b0, 1'b1, 1'b0, 8'h00);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dflags(i) !== C_IDLE_EMPTY) begin
                errors++;
                $display("FAIL drained_state[%0d]: got %b expected %b", i, dflags(i), C_IDLE_EMPTY);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_d;
        do_reset();
        op(1'b1, 1'b0, 1'b0, 8'h01);
        op(1'b1, 1'b0, 1'b0, 8'h02);
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (cnt[i] !== 3'd2 || dout[i] !== mhead(i)) begin
                    errors++;
                    $display("FAIL wrap_stream%0d[%0d]: got cnt=%0d d=%h expected cnt=2 d=%h",
                             k, i, cnt[i], dout[i], mhead(i));
                end
            end
            op(1'b1, 1'b1, 1'b0, 8'hA0 + 8'(k));
        end
        for (int k = 0; k < 2; k++) begin
            exp_d = 8'hA8 + 8'(k);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dout[i] !== exp_d || ovf[i] !== 1'b0 || unf[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_tail%0d[%0d]: got d=%h ovf=%b unf=%b expected d=%h ovf=0 unf=0",
                             k, i, dout[i], ovf[i], unf[i], exp_d);
                end
            end
            op(1'b0, 1'b1, 1'b0, 8'h00);
        end
    endtask

    task automatic test_full_boundary();
        do_reset();
        for (int k = 0; k < 4; k++) op(1'b1, 1'b0, 1'b0, 8'h11 * 8'(k + 1));
        op(1'b1, 1'b1, 1'b0, 8'h55);
        checks++;
        if (cnt[0] !== 3'd3 || ovf[0] !== 1'b1) begin
            errors++;
            $display("FAIL full_guarded: got cnt=%0d ovf=%b expected cnt=3 ovf=1", cnt[0], ovf[0]);
        end
        checks++;
        if (cnt[1] !== 3'd4 || ovf[1] !== 1'b0) begin
            errors++;
            $display("FAIL full_unguarded: got cnt=%0d ovf=%b expected cnt=4 ovf=0", cnt[1], ovf[1]);
        end
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (msize(i) > 0) begin
                    checks++;
                    if (dout[i] !== mhead(i)) begin
                        errors++;
                        $display("FAIL full_drain%0d[%0d]: got %h expected %h", k, i, dout[i], mhead(i));
                    end
                end
            end
            op(1'b0, 1'b1, 1'b0, 8'h00);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dflags(i) !== mflags(i)) begin
                errors++;
                $display("FAIL full_after[%0d]: got %b expected %b", i, dflags(i), mflags(i));
            end
        end
    endtask

    task automatic test_empty_boundary();
        do_reset();
        op(1'b1, 1'b1, 1'b0, 8'h77);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (unf[i] !== 1'b1 || cnt[i] !== 3'd1 || dout[i] !== 8'h77 || ovf[i] !== 1'b0) begin
                errors++;
                $display("FAIL empty_enq_deq[%0d]: got unf=%b cnt=%0d d=%h ovf=%b expected unf=1 cnt=1 d=77 ovf=0",
                         i, unf[i], cnt[i], dout[i], ovf[i]);
            end
        end
        op(1'b0, 1'b1, 1'b0, 8'h00);
        op(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (unf[i] !== 1'b1 || cnt[i] !== 3'd0 || en[i] !== 1'b0) begin
                errors++;
                $display("FAIL empty_deq_only[%0d]: got unf=%b cnt=%0d en=%b expected unf=1 cnt=0 en=0",
                         i, unf[i], cnt[i], en[i]);
            end
        end
    endtask

    task automatic test_clr();
        do_reset();
        op(1'b0, 1'b1, 1'b0, 8'h00);           // leave UNF set before the clear
        for (int k = 0; k < 3; k++) op(1'b1, 1'b0, 1'b0, 8'hC0 + 8'(k));
        op(1'b1, 1'b0, 1'b1, 8'hEE);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dflags(i) !== 9'b000_1_0_0_1_0_1) begin
                errors++;
                $display("FAIL clr_state[%0d]: got %b expected %b", i, dflags(i), 9'b000_1_0_0_1_0_1);
            end
        end
        op(1'b1, 1'b0, 1'b0, 8'h99);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dout[i] !== 8'h99 || cnt[i] !== 3'd1) begin
                errors++;
                $display("FAIL clr_then_enq[%0d]: got d=%h cnt=%0d expected d=99 cnt=1", i, dout[i], cnt[i]);
            end
        end
    endtask

    task automatic test_random();
        int bias;
        bit e;
        bit d;
        bit c;
        do_reset();
        bias = 2;
        for (int k = 0; k < 400; k++) begin
            if (k % 40 == 0) bias = $urandom_range(1, 3);
            e = ($urandom_range(0, 3) < bias);
            d = ($urandom_range(0, 3) < (4 - bias));
            c = ($urandom_range(0, 31) == 0);
            op(e, d, c, 8'($urandom));
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dflags(i) !== mflags(i)) begin
                    errors++;
                    $display("FAIL random_status%0d[%0d]: got %b expected %b", k, i, dflags(i), mflags(i));
                end
                if (msize(i) > 0) begin
                    checks++;
                    if (dout[i] !== mhead(i)) begin
                        errors++;
                        $display("FAIL random_data%0d[%0d]: got %h expected %h", k, i, dout[i], mhead(i));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_boundary();
        test_empty_boundary();
        test_clr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/sized_fifo_lvl.md
Name: sized_fifo_lvl

Overview:
Parametrised-depth synchronous FIFO, the multi-entry successor to the team's depth-1 FIFO. It keeps the same ENQ/DEQ/FULL_N/EMPTY_N/CLR handshake and adds:
- occupancy count
- programmable almost-full / almost-empty flags
- sticky overflow/underflow error flags

It sits between producer and consumer rules wherever more than one entry of slack is needed.

Parameters:
width, 8, data width in bits (>=1)
depth, 4, number of entries (power of two, >=2)
aw, 2, log2(depth); pointer width
af_level, 3, ALMOST_FULL asserts when count >= af_level (1..depth)
ae_level, 1, ALMOST_EMPTY asserts when count <= ae_level (0..depth-1)
guarded, 1, 1: ENQ while full is rejected even with DEQ; 0: ENQ+DEQ while full is allowed (pass-through slot reuse)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  reset, synchronous, active-high
D_IN  in  width  enqueue data
ENQ  in  1  enqueue request
DEQ  in  1  dequeue request
CLR  in  1  synchronous clear
D_OUT  out  width  head entry data
FULL_N  out  1  1 = at least one free entry
EMPTY_N  out  1  1 = at least one valid entry
COUNT  out  aw+1  current occupancy, 0..depth
ALMOST_FULL  out  1  count >= af_level
ALMOST_EMPTY  out  1  count <= ae_level
OVF  out  1  sticky: rejected enqueue occurred
UNF  out  1  sticky: rejected dequeue occurred

Behaviour:
- Reset, and CLR, on the rising edge:
  - rd_ptr = 0, wr_ptr = 0, count = 0.
  - FULL_N = 1, EMPTY_N = 0, ALMOST_EMPTY = 1, ALMOST_FULL = 0.
  - RST also clears OVF and UNF. CLR does not clear them.
  - Storage array is not reset. D_OUT is undefined while EMPTY_N = 0.
- Priority: RST > CLR > ENQ/DEQ. With CLR = 1, ENQ and DEQ are ignored that cycle and no error is flagged.
- Storage and pointers:
  - Register array mem[depth].
  - D_OUT = mem[rd_ptr], a combinational read of the registered array.
  - Pointers are aw bits and wrap modulo depth.
- Enqueue accepted (enq_ok):
  - Condition: ENQ && (count < depth || (!guarded && DEQ && count == depth)).
  - Effect: mem[wr_ptr] <= D_IN; wr_ptr++.
- Dequeue accepted (deq_ok):
  - Condition: DEQ && count > 0.
  - Effect: rd_ptr++.
- Count update: count += enq_ok - deq_ok, so simultaneous accepted ENQ+DEQ leaves count unchanged.
- Simultaneous ENQ+DEQ when empty: DEQ is rejected (UNF set), ENQ is accepted, count becomes 1. There is no bypass: data is first visible on D_OUT one cycle after enqueue.
- Simultaneous ENQ+DEQ when full:
  - guarded = 1: ENQ rejected (OVF set), DEQ accepted, count becomes depth-1.
  - guarded = 0: both accepted, count stays depth, and the freed slot is written.
- Errors:
  - ENQ not accepted (and CLR = 0) sets OVF.
  - DEQ not accepted (and CLR = 0) sets UNF.
  - Both are sticky until RST.
  - Simulation-only $display warnings on the same conditions.
- Output timing: FULL_N, EMPTY_N, COUNT, ALMOST_* are registered, or derived purely from registered count. They change only on the clock edge following the operation. Latency ENQ -> EMPTY_N = 1 cycle.
- FULL_N = (count != depth), EMPTY_N = (count != 0).
- Wrap-around: after depth accepted enqueues and dequeues, pointers return to 0 with no data loss or reordering.

Test Plan:
- Reset then idle: assert RST 2 cycles -> COUNT = 0, EMPTY_N = 0, FULL_N = 1, ALMOST_EMPTY = 1, OVF = UNF = 0.
- Fill and drain: enqueue 0x11, 0x22, 0x33, 0x44 on consecutive cycles. After the 3rd, ALMOST_FULL = 1; after the 4th, FULL_N = 0 and COUNT = 4. Dequeue 4 times -> D_OUT sequence 0x11, 0x22, 0x33, 0x44, then EMPTY_N = 0, no errors.
- Wrap-around streaming: 10 cycles of simultaneous ENQ+DEQ (data 0xA0..0xA9) after pre-loading 2 entries -> COUNT stays 2, outputs are in order, pointers wrap.
- Full boundary, guarded = 1: at count 4, ENQ = DEQ = 1 with D_IN = 0x55 -> COUNT = 3, OVF = 1, 0x55 never appears. Repeat with guarded = 0 -> COUNT = 4, OVF = 0, 0x55 emerges after the existing 4 entries.
- Empty boundary: at count 0, ENQ = DEQ = 1 with D_IN = 0x77 -> UNF = 1, COUNT = 1, D_OUT = 0x77 next cycle. DEQ alone at count 0 -> UNF stays 1, COUNT stays 0.
- CLR mid-operation: at count 3, pulse CLR together with ENQ -> COUNT = 0, EMPTY_N = 0, OVF/UNF unchanged. The next ENQ of 0x99 yields D_OUT = 0x99.
